// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with strobe-gated FSM (IDLE/EXEC/MUL/DONE).
// Define SEQ_ALU_MUL_EN to include the shift-add multiplier; otherwise OP=1001 is illegal.
module seq_alu #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 4
) (
  input  logic                          CLK,
  input  logic                          ARST_L,
  input  logic                          SLOW_CLOCK_STRB,
  input  logic                          START,
  input  logic [3:0]                    OP,
  input  logic [$clog2(NUM_REGS)-1:0]   SEL_A,
  input  logic [$clog2(NUM_REGS)-1:0]   SEL_B,
  input  logic [NUM_REGS*WIDTH-1:0]     REGS_IN,
  output logic [WIDTH-1:0]              OUT,
  output logic                          BUSY,
  output logic                          DONE,
  output logic [3:0]                    CONDITION_REG
);

  localparam int SELW = $clog2(NUM_REGS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;
  localparam logic [3:0] OP_LSL = 4'b0110;
  localparam logic [3:0] OP_LSR = 4'b0111;
  localparam logic [3:0] OP_ASR = 4'b1000;
  localparam logic [3:0] OP_AND = 4'b1010;
  localparam logic [3:0] OP_OR  = 4'b1011;
  localparam logic [3:0] OP_XOR = 4'b1100;

  localparam logic [WIDTH-1:0] WIDTH_VAL = WIDTH'(WIDTH);

`ifdef SEQ_ALU_MUL_EN
  localparam logic [1:0] ST_MUL = 2'd2;
  localparam logic [3:0] OP_MUL = 4'b1001;
  localparam int         CW     = $clog2(WIDTH) + 1;
`endif

  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic [3:0]        op_reg;
  logic [WIDTH-1:0]  out_reg;
  logic [3:0]        flags_reg;

  logic [WIDTH-1:0]  regs_arr [NUM_REGS];
  logic [WIDTH-1:0]  a_sel;
  logic [WIDTH-1:0]  b_sel;

  logic [WIDTH-1:0]    alu_out;
  logic                alu_c;
  logic                alu_v;
  logic [3:0]          alu_flags;
  logic [WIDTH:0]      sum_wide;
  logic [WIDTH:0]      diff_wide;
  logic [2*WIDTH-1:0]  shl_wide;
  logic                shamt_big;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs
      assign regs_arr[gi] = REGS_IN[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign a_sel = regs_arr[SEL_A];
  assign b_sel = regs_arr[SEL_B];

`ifdef SEQ_ALU_MUL_EN
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] mul_addend;
  logic [2*WIDTH-1:0] mul_prod;
  logic               mul_last;
  logic [3:0]         mul_flags;

  assign mul_addend = mplier_reg[0] ? mcand_reg : '0;
  assign mul_prod   = acc_reg + mul_addend;
  assign mul_last   = (cnt_reg == CW'(WIDTH - 1));
  // V: anything at or above bit WIDTH-1 means the product exceeds the positive signed range
  assign mul_flags  = {mul_prod[WIDTH-1],
                       (mul_prod[WIDTH-1:0] == '0),
                       |mul_prod[2*WIDTH-1:WIDTH],
                       |mul_prod[2*WIDTH-1:WIDTH-1]};
`endif

  // Single-cycle datapath; evaluated from the latched operands while in EXEC
  always_comb begin
    alu_out   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    sum_wide  = {1'b0, a_reg} + {1'b0, b_reg};
    diff_wide = {1'b0, a_reg} - {1'b0, b_reg};
    shl_wide  = {{WIDTH{1'b0}}, a_reg} << b_reg;
    shamt_big = (b_reg >= WIDTH_VAL);
    case (op_reg)
      OP_ADD: begin
        alu_out = sum_wide[WIDTH-1:0];
        alu_c   = sum_wide[WIDTH];
        alu_v   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (alu_out[WIDTH-1] != a_reg[WIDTH-1]);
      end
      OP_SUB: begin
        alu_out = diff_wide[WIDTH-1:0];
        alu_c   = diff_wide[WIDTH];
        alu_v   = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (alu_out[WIDTH-1] != a_reg[WIDTH-1]);
      end
      OP_LSL: begin
        alu_out = shamt_big ? '0 : shl_wide[WIDTH-1:0];
        alu_c   = shamt_big ? |a_reg : |shl_wide[2*WIDTH-1:WIDTH];
      end
      OP_LSR: alu_out = shamt_big ? '0 : (a_reg >> b_reg);
      OP_ASR: alu_out = shamt_big ? {WIDTH{a_reg[WIDTH-1]}} : WIDTH'($signed(a_reg) >>> b_reg);
      OP_AND: alu_out = a_reg & b_reg;
      OP_OR:  alu_out = a_reg | b_reg;
      OP_XOR: alu_out = a_reg ^ b_reg;
      default: begin
        alu_out = '0;
      end
    endcase
    // Illegal opcodes leave out/c/v at zero, which yields NZCV=0100 here
    alu_flags = {alu_out[WIDTH-1], (alu_out == '0), alu_c, alu_v};
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (START) begin
`ifdef SEQ_ALU_MUL_EN
          state_next = (OP == OP_MUL) ? ST_MUL : ST_EXEC;
`else
          state_next = ST_EXEC;
`endif
        end
      end
      ST_EXEC: state_next = ST_DONE;
`ifdef SEQ_ALU_MUL_EN
      ST_MUL:  state_next = mul_last ? ST_DONE : ST_MUL;
`endif
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!ARST_L) begin
      state_reg <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
      out_reg   <= '0;
      flags_reg <= '0;
`ifdef SEQ_ALU_MUL_EN
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
`endif
    end else if (SLOW_CLOCK_STRB) begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (START) begin
            a_reg  <= a_sel;
            b_reg  <= b_sel;
            op_reg <= OP;
`ifdef SEQ_ALU_MUL_EN
            mcand_reg  <= {{WIDTH{1'b0}}, a_sel};
            mplier_reg <= b_sel;
            acc_reg    <= '0;
            cnt_reg    <= '0;
`endif
          end
        end
        ST_EXEC: begin
          out_reg   <= alu_out;
          flags_reg <= alu_flags;
        end
`ifdef SEQ_ALU_MUL_EN
        ST_MUL: begin
          acc_reg    <= mul_prod;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + 1'b1;
          if (mul_last) begin
            out_reg   <= mul_prod[WIDTH-1:0];
            flags_reg <= mul_flags;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

  assign OUT           = out_reg;
  assign CONDITION_REG = flags_reg;
  assign BUSY          = (state_reg != ST_IDLE);
  assign DONE          = (state_reg == ST_DONE);

endmodule
